// File: rtl/mem_lsu_if.sv
// Request/response and data-bus signal bundle for the mem_lsu load/store unit.
// slave = the LSU itself; master = its environment (execute stage plus bus).
interface mem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_unsigned;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_op_fault;
  logic              resp_addr_fault;
  logic              resp_acc_fault;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wstrb;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport slave (
    input  req_valid, req_write, req_unsigned, req_op, req_addr, req_wdata,
           resp_ready, bus_ready, bus_rvalid, bus_rdata, bus_err,
    output req_ready, resp_valid, resp_rdata, resp_op_fault, resp_addr_fault,
           resp_acc_fault, bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output req_valid, req_write, req_unsigned, req_op, req_addr, req_wdata,
           resp_ready, bus_ready, bus_rvalid, bus_rdata, bus_err,
    input  req_ready, resp_valid, resp_rdata, resp_op_fault, resp_addr_fault,
           resp_acc_fault, bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: op/alignment check, byte-lane steering, bus handshake with timeout.
// Optional address-window check enabled by defining LSU_ACCESS_WINDOW_EN.
module mem_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
`ifdef LSU_ACCESS_WINDOW_EN
  ,
  parameter logic [ADDR_W-1:0] WIN_BASE = '0,
  parameter logic [ADDR_W:0]   WIN_SIZE = {1'b0, {ADDR_W{1'b1}}}
`endif
) (
  input logic       clk,
  input logic       reset,
  mem_lsu_if.slave  lsu
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [OFF_W-1:0] off_q;
  logic             uns_q;
  logic             write_q;
  logic             accept;
  logic             op_bad;
  logic             misaligned;
  logic             win_bad;
  logic             fault_now;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] op, input logic [OFF_W-1:0] off);
    logic [7:0] m;
    case (op)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return NB'(m) << off;
  endfunction

  function automatic logic [XLEN-1:0] replicate(input logic [1:0] op, input logic [XLEN-1:0] d);
    case (op)
      2'b00:   return {NB{d[7:0]}};
      2'b01:   return {(NB/2){d[15:0]}};
      2'b10:   return {(NB/4){d[31:0]}};
      default: return d;
    endcase
  endfunction

  // Move the addressed lanes down to bit 0, then extend to the full width.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d, input logic [OFF_W-1:0] off,
                                             input logic [1:0] op, input logic uns);
    logic [XLEN-1:0]    sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    sh = d >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (op)
      2'b00:   return uns ? XLEN'(sh[7:0])  : XLEN'(b);
      2'b01:   return uns ? XLEN'(sh[15:0]) : XLEN'(h);
      2'b10:   return uns ? XLEN'(sh[31:0]) : XLEN'(w);
      default: return sh;
    endcase
  endfunction

  assign accept = lsu.req_valid && lsu.req_ready;

  always_comb begin
    op_bad     = (XLEN == 32) && (lsu.req_op == 2'b11);
    misaligned = 1'b0;
    case (lsu.req_op)
      2'b01:   misaligned = lsu.req_addr[0];
      2'b10:   misaligned = |lsu.req_addr[1:0];
      2'b11:   misaligned = (|lsu.req_addr[2:0]) && !op_bad;
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_ACCESS_WINDOW_EN
  // Extra headroom bits keep base+size and addr+bytes from wrapping.
  logic [ADDR_W+1:0] win_lo;
  logic [ADDR_W+1:0] win_end;
  logic [ADDR_W+1:0] acc_end;
  always_comb begin
    win_lo  = {2'b00, WIN_BASE};
    win_end = {2'b00, WIN_BASE} + {1'b0, WIN_SIZE};
    acc_end = {2'b00, lsu.req_addr} + (ADDR_W+2)'(4'd1 << lsu.req_op);
    win_bad = ({2'b00, lsu.req_addr} < win_lo) || (acc_end > win_end);
  end
`else
  assign win_bad = 1'b0;
`endif

  assign fault_now = op_bad || misaligned || win_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      lsu.req_ready       <= 1'b1;
      lsu.bus_valid       <= 1'b0;
      lsu.resp_valid      <= 1'b0;
      lsu.resp_op_fault   <= 1'b0;
      lsu.resp_addr_fault <= 1'b0;
      lsu.resp_acc_fault  <= 1'b0;
      cnt                 <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lsu.req_ready <= 1'b0;
          if (fault_now) begin
            state               <= RESP;
            lsu.resp_valid      <= 1'b1;
            lsu.resp_op_fault   <= op_bad;
            lsu.resp_addr_fault <= misaligned;
            lsu.resp_acc_fault  <= 1'b1;
          end else begin
            state               <= REQ;
            lsu.bus_valid       <= 1'b1;
            lsu.resp_op_fault   <= 1'b0;
            lsu.resp_addr_fault <= 1'b0;
            lsu.resp_acc_fault  <= 1'b0;
          end
        end
        REQ: if (lsu.bus_ready) begin
          state         <= WAIT;
          lsu.bus_valid <= 1'b0;
          cnt           <= '0;
        end
        WAIT: begin
          // A response arriving in the timeout cycle still counts as normal.
          if (lsu.bus_rvalid) begin
            state              <= RESP;
            lsu.resp_valid     <= 1'b1;
            lsu.resp_acc_fault <= lsu.bus_err;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            state              <= RESP;
            lsu.resp_valid     <= 1'b1;
            lsu.resp_acc_fault <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (lsu.resp_ready) begin
          state          <= IDLE;
          lsu.resp_valid <= 1'b0;
          lsu.req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request and response data registers carry no reset; control gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q           <= lsu.req_op;
      off_q          <= lsu.req_addr[OFF_W-1:0];
      uns_q          <= lsu.req_unsigned;
      write_q        <= lsu.req_write;
      lsu.bus_write  <= lsu.req_write;
      lsu.bus_addr   <= lsu.req_addr & ~ADDR_W'(NB - 1);
      lsu.bus_wdata  <= replicate(lsu.req_op, lsu.req_wdata);
      lsu.bus_wstrb  <= lsu.req_write ? lane_mask(lsu.req_op, lsu.req_addr[OFF_W-1:0]) : '0;
      lsu.resp_rdata <= '0;
    end
    if ((state == WAIT) && lsu.bus_rvalid) begin
      lsu.resp_rdata <= (write_q || lsu.bus_err) ? '0 : extract(lsu.bus_rdata, off_q, op_q, uns_q);
    end
  end
endmodule
